scalar_rf_perf: RTL and testbench

- Parametrised next-generation scalar register file for the vector/scalar processor.
- Generalises register count, width and read-port count, and adds same-cycle write-to-read bypass.
- Replaces the combinational divide with a multi-cycle iterative divider for cycles-per-instruction.
- Registers the performance-counter outputs and keeps the finish detect. Sits between decode (reads) and writeback (writes).

---
 rtl/scalar_rf_perf_pkg.sv | 11 +
 rtl/scalar_rf_perf_if.sv | 29 ++
 rtl/scalar_rf_perf_div.sv | 78 +++++++
 rtl/scalar_rf_perf.sv | 83 ++++++++
 tb/tb_scalar_rf_perf.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/scalar_rf_perf_pkg.sv
// scalar_rf_pkg: shared divider state type and default register-map constants
// for the scalar register file (cycle counter, CPI target, finish detect, reset seeds).
package scalar_rf_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, ITER, WRITE} div_state_t;
   localparam int CYCLE_REG_DEF  = 27;
   localparam int CPI_REG_DEF    = 31;
   localparam int FINISH_REG_DEF = 28;
   localparam int FINISH_VAL_DEF = 333;
   localparam int INIT_R1_DEF    = 200000;
   localparam int INIT_R10_DEF   = 199983;
endpackage

// File: rtl/scalar_rf_perf_if.sv
// scalar_rf_perf_if: bus between decode/writeback and the scalar register file.
//   rs/rdata        : NREAD packed read ports (decode side)
//   rd_addr/wd/we   : single write port (writeback side)
//   *_count         : pipeline event counts in; *_q registered copies out
//   cpi/cpi_valid/div_busy/finish : performance status out
// master drives requests (pipeline), slave is the register file.
interface scalar_rf_perf_if #(
   parameter int WIDTH = 19,
   parameter int NREGS = 32,
   parameter int NREAD = 3
);
   localparam int AW = $clog2(NREGS);
   logic [NREAD*AW-1:0]    rs;
   logic [NREAD*WIDTH-1:0] rdata;
   logic [AW-1:0]          rd_addr;
   logic [WIDTH-1:0]       wd;
   logic                   we;
   logic [WIDTH-1:0]       stall_count, arith_count, mem_count, instr_count;
   logic [WIDTH-1:0]       stall_q, arith_q, mem_q, cpi;
   logic                   cpi_valid, div_busy, finish;
   modport master (
      output rs, rd_addr, wd, we, stall_count, arith_count, mem_count, instr_count,
      input  rdata, stall_q, arith_q, mem_q, cpi, cpi_valid, div_busy, finish
   );
   modport slave (
      input  rs, rd_addr, wd, we, stall_count, arith_count, mem_count, instr_count,
      output rdata, stall_q, arith_q, mem_q, cpi, cpi_valid, div_busy, finish
   );
endinterface

// File: rtl/scalar_rf_perf_div.sv
// iter_divider: unsigned restoring divider, one quotient bit per cycle.
//   start    : sampled in IDLE; launches LOAD
//   dividend/divisor : snapshotted in LOAD
//   busy     : registered, high in LOAD and ITER
//   done     : registered, high for the single WRITE cycle
//   quotient : valid while done is high
module iter_divider
   import scalar_rf_pkg::*;
#(
   parameter int WIDTH = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);
   localparam int CW = $clog2(WIDTH + 1);
   div_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH:0]   rem_sh, diff;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      // quo_q doubles as the dividend shift register: its MSB feeds the remainder
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, dvs_q};
      case (state_q)
         IDLE: state_d = start ? LOAD : IDLE;
         LOAD: begin
            quo_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = ITER;
         end
         ITER: begin
            // diff MSB set means the trial subtraction borrowed: restore
            rem_d   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(WIDTH - 1)) ? WRITE : ITER;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == LOAD) || (state_d == ITER);
      done_d = (state_d == WRITE);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = quo_q;
endmodule

// File: rtl/scalar_rf_perf.sv
// scalar_rf_perf: parametrised scalar register file with write-to-read bypass,
// free-running cycle counter, iterative CPI divider and finish detect.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : scalar_rf_perf_if.slave (read ports, write port, event counts,
//                registered counts, cpi/cpi_valid/div_busy/finish)
module scalar_rf_perf
   import scalar_rf_pkg::*;
#(
   parameter int WIDTH      = 19,
   parameter int NREGS      = 32,
   parameter int NREAD      = 3,
   parameter int CYCLE_REG  = CYCLE_REG_DEF,
   parameter int CPI_REG    = CPI_REG_DEF,
   parameter int FINISH_REG = FINISH_REG_DEF,
   parameter int FINISH_VAL = FINISH_VAL_DEF,
   parameter int INIT_R1    = INIT_R1_DEF,
   parameter int INIT_R10   = INIT_R10_DEF
) (
   input logic            clk,
   input logic            rst_n,
   scalar_rf_perf_if.slave bus
);
   localparam int AW = $clog2(NREGS);
   logic [WIDTH-1:0]       regs_q [NREGS];
   logic [WIDTH-1:0]       regs_d [NREGS];
   logic [WIDTH-1:0]       stall_q, stall_d, arith_q, arith_d, mem_q, mem_d;
   logic                   cpi_valid_q, cpi_valid_d;
   logic [NREAD*WIDTH-1:0] rdata_c;
   logic                   div_busy, div_done;
   logic [WIDTH-1:0]       div_quot;
   iter_divider #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (bus.instr_count != '0),
      .dividend (regs_q[CYCLE_REG]),
      .divisor  (bus.instr_count),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quot)
   );
   always_comb begin
      rdata_c = '0;
      for (int i = 0; i < NREAD; i++)
         rdata_c[i*WIDTH +: WIDTH] = (bus.we && bus.rd_addr == bus.rs[i*AW +: AW])
                                     ? bus.wd : regs_q[bus.rs[i*AW +: AW]];
   end
   // Later assignments take priority: architectural write beats both the
   // counter increment and the divider result. AW bits address exactly NREGS.
   always_comb begin
      regs_d = regs_q;
      regs_d[CYCLE_REG] = regs_q[CYCLE_REG] + WIDTH'(1);
      if (div_done) regs_d[CPI_REG] = div_quot;
      if (bus.we) regs_d[bus.rd_addr] = bus.wd;
      // pulse lands in the same cycle the new quotient is visible on cpi
      cpi_valid_d = div_done && !(bus.we && bus.rd_addr == AW'(CPI_REG));
      stall_d = bus.stall_count;
      arith_d = bus.arith_count;
      mem_d   = bus.mem_count;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= (i == 1) ? WIDTH'(INIT_R1) : (i == 10) ? WIDTH'(INIT_R10) : '0;
         stall_q     <= '0;
         arith_q     <= '0;
         mem_q       <= '0;
         cpi_valid_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         stall_q     <= stall_d;
         arith_q     <= arith_d;
         mem_q       <= mem_d;
         cpi_valid_q <= cpi_valid_d;
      end
   assign bus.rdata     = rdata_c;
   assign bus.stall_q   = stall_q;
   assign bus.arith_q   = arith_q;
   assign bus.mem_q     = mem_q;
   assign bus.cpi       = regs_q[CPI_REG];
   assign bus.cpi_valid = cpi_valid_q;
   assign bus.div_busy  = div_busy;
   assign bus.finish    = regs_q[FINISH_REG] == WIDTH'(FINISH_VAL);
endmodule

// File: tb/tb_scalar_rf_perf.sv
// tb_scalar_rf_perf: table-driven read/write/bypass checks plus scoreboarded
// divider and event-count sequences for scalar_rf_perf.
module tb_scalar_rf_perf;
   import scalar_rf_pkg::*;
   logic clk, rst_n;
   int   checks = 0, fails = 0;
   scalar_rf_perf_if bus ();
   scalar_rf_perf dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [18:0] wd;
      logic [4:0]  rs0, rs1;
      logic [18:0] exp0, exp1;
      logic        fin;
   } vec_t;
   typedef struct packed {logic [18:0] s, a, m;} cnt_t;
   vec_t        vecs [15];
   logic [18:0] exp_q [$];
   cnt_t        cq [$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask
   // Steps from the current start cycle until cpi_valid, checking latency and value.
   task automatic wait_valid(input int budget, input int exp_k, input int chg_k, input logic [18:0] chg_val);
      int k;
      bit got;
      logic [18:0] e;
      got = 0;
      for (k = 1; k <= budget; k++) begin
         @(posedge clk); #1;
         if (k == chg_k) bus.instr_count = chg_val;
         @(negedge clk);
         if (k == 1) chk("busy_in_load", bus.div_busy, 1);
         if (k == exp_k - 1) chk("busy_in_write", bus.div_busy, 0);
         if (bus.cpi_valid) begin
            got = 1;
            break;
         end
      end
      chk("cpi_latency", got ? k : -1, exp_k);
      if (got) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL cpi_unexpected actual=%0d required=none", bus.cpi);
         end else begin
            e = exp_q.pop_front();
            chk("cpi_value", bus.cpi, e);
         end
      end
   endtask
   initial begin
      cnt_t c;
      int pulses;
      vecs[0]  = '{1'b1, 5'd5,  19'd1234,    5'd5,  5'd1,  19'd1234,    19'd200000,  1'b0};
      vecs[1]  = '{1'b0, 5'd0,  19'd0,       5'd5,  5'd6,  19'd1234,    19'd0,       1'b0};
      vecs[2]  = '{1'b1, 5'd28, 19'd333,     5'd28, 5'd5,  19'd333,     19'd1234,    1'b0};
      vecs[3]  = '{1'b0, 5'd0,  19'd0,       5'd28, 5'd0,  19'd333,     19'd0,       1'b1};
      vecs[4]  = '{1'b1, 5'd0,  19'd77,      5'd0,  5'd28, 19'd77,      19'd333,     1'b1};
      vecs[5]  = '{1'b1, 5'd28, 19'd0,       5'd0,  5'd28, 19'd77,      19'd0,       1'b1};
      vecs[6]  = '{1'b0, 5'd0,  19'd0,       5'd28, 5'd0,  19'd0,       19'd77,      1'b0};
      vecs[7]  = '{1'b1, 5'd1,  19'h7FFFF,   5'd1,  5'd10, 19'h7FFFF,   19'd199983,  1'b0};
      vecs[8]  = '{1'b0, 5'd0,  19'd0,       5'd1,  5'd1,  19'h7FFFF,   19'h7FFFF,   1'b0};
      vecs[9]  = '{1'b1, 5'd31, 19'd55,      5'd31, 5'd0,  19'd55,      19'd77,      1'b0};
      vecs[10] = '{1'b0, 5'd0,  19'd0,       5'd31, 5'd2,  19'd55,      19'd0,       1'b0};
      vecs[11] = '{1'b1, 5'd27, 19'd500,     5'd27, 5'd31, 19'd500,     19'd55,      1'b0};
      vecs[12] = '{1'b0, 5'd0,  19'd0,       5'd27, 5'd27, 19'd500,     19'd500,     1'b0};
      vecs[13] = '{1'b0, 5'd0,  19'd0,       5'd27, 5'd1,  19'd501,     19'h7FFFF,   1'b0};
      vecs[14] = '{1'b1, 5'd10, 19'd3,       5'd10, 5'd10, 19'd3,       19'd3,       1'b0};
      bus.rs = '0; bus.rd_addr = '0; bus.wd = '0; bus.we = 1'b0;
      bus.stall_count = '0; bus.arith_count = '0; bus.mem_count = '0; bus.instr_count = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int r = 0; r < 32; r++) begin
         bus.rs = {5'd0, 5'd0, 5'(r)};
         #1;
         chk($sformatf("reset_r%0d", r), bus.rdata[18:0], r == 1 ? 200000 : r == 10 ? 199983 : 0);
      end
      chk("reset_busy", bus.div_busy, 0);
      chk("reset_valid", bus.cpi_valid, 0);
      chk("reset_stall_q", bus.stall_q, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      bus.rs = {5'd0, 5'd0, 5'd1};
      @(negedge clk);
      chk("post_reset_r1", bus.rdata[18:0], 200000);
      chk("post_reset_finish", bus.finish, 0);
      chk("post_reset_valid", bus.cpi_valid, 0);
      chk("post_reset_cpi", bus.cpi, 0);
      foreach (vecs[i]) begin
         @(posedge clk); #1;
         bus.we = vecs[i].we; bus.rd_addr = vecs[i].addr; bus.wd = vecs[i].wd;
         bus.rs = {vecs[i].rs0, vecs[i].rs1, vecs[i].rs0};
         @(negedge clk);
         chk($sformatf("vec%0d_rdata0", i), bus.rdata[18:0], vecs[i].exp0);
         chk($sformatf("vec%0d_rdata1", i), bus.rdata[37:19], vecs[i].exp1);
         chk($sformatf("vec%0d_rdata2", i), bus.rdata[56:38], vecs[i].exp0);
         chk($sformatf("vec%0d_finish", i), bus.finish, vecs[i].fin);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         bus.we = 1'b0;
         bus.stall_count = 19'(i * 7 + 1);
         bus.arith_count = 19'(i * 100 + 3);
         bus.mem_count   = 19'h7FFFF - 19'(i);
         @(negedge clk);
         if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("stall_q", bus.stall_q, c.s);
            chk("arith_q", bus.arith_q, c.a);
            chk("mem_q", bus.mem_q, c.m);
         end
         cq.push_back({bus.stall_count, bus.arith_count, bus.mem_count});
      end
      // single division: R27=999 -> 1000 at LOAD, divisor 10 changed to 0 mid-ITER
      @(posedge clk); #1;
      bus.we = 1'b1; bus.rd_addr = 5'd27; bus.wd = 19'd999;
      @(posedge clk); #1;
      bus.we = 1'b0; bus.instr_count = 19'd10;
      exp_q.push_back(19'd100);
      @(negedge clk);
      chk("idle_not_busy", bus.div_busy, 0);
      wait_valid(40, 22, 2, 19'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("valid_one_pulse", bus.cpi_valid, 0);
      // back-to-back: R27=99 at start, divisor 5 -> 100/5 then 122/5
      @(posedge clk); #1;
      bus.we = 1'b1; bus.rd_addr = 5'd27; bus.wd = 19'd99;
      @(posedge clk); #1;
      bus.we = 1'b0; bus.instr_count = 19'd5;
      exp_q.push_back(19'd20);
      exp_q.push_back(19'd24);
      @(negedge clk);
      wait_valid(40, 22, -1, 19'd0);
      wait_valid(40, 22, -1, 19'd0);
      // third division runs into ITER, then reset aborts it
      repeat (4) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("busy_mid_iter", bus.div_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.div_busy, 0);
      chk("abort_cpi", bus.cpi, 0);
      chk("abort_valid", bus.cpi_valid, 0);
      bus.instr_count = 19'd1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.push_back(19'd1);
      @(negedge clk);
      chk("restart_idle", bus.div_busy, 0);
      wait_valid(40, 22, 2, 19'd0);
      // idle: instr_count=0 for 100 cycles
      @(posedge clk); #1;
      bus.we = 1'b1; bus.rd_addr = 5'd27; bus.wd = 19'd1000;
      @(posedge clk); #1;
      bus.we = 1'b0;
      pulses = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.div_busy || bus.cpi_valid) pulses++;
         @(posedge clk); #1;
      end
      bus.rs = {5'd0, 5'd0, 5'd27};
      #1;
      chk("idle_activity", pulses, 0);
      chk("idle_cycle_reg", bus.rdata[18:0], 1100);
      chk("idle_cpi_hold", bus.cpi, 1);
      // architectural write to CPI_REG in the WRITE cycle wins
      @(posedge clk); #1;
      bus.instr_count = 19'd1;
      pulses = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (k == 2) bus.instr_count = 19'd0;
         bus.we = (k == 21); bus.rd_addr = 5'd31; bus.wd = 19'd4242;
         @(negedge clk);
         if (bus.cpi_valid) pulses++;
      end
      chk("conflict_no_valid", pulses, 0);
      chk("conflict_cpi", bus.cpi, 4242);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
